// File: rtl/channel_sweep_if.sv
`default_nettype none
// ============================================================================
// Module   : channel_sweep_if
// Brief    : Host/channel/checker-side signals of the noise-sweep controller.
//            The abort line exists only when CHAN_SWEEP_ABORT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface channel_sweep_if #(
  parameter int CNT_W = 16
);
  logic                start;
  logic                sym_valid;
  logic                sym_err;
  logic                res_ready;
  logic signed [17:0]  noise_scale;
  logic                noise_en;
  logic                busy;
  logic                res_valid;
  logic [7:0]          res_step;
  logic signed [17:0]  res_scale;
  logic [CNT_W-1:0]    res_errs;
  logic                done;
`ifdef CHAN_SWEEP_ABORT_EN
  logic                abort;

  modport master (
    input  start, sym_valid, sym_err, res_ready, abort,
    output noise_scale, noise_en, busy, res_valid, res_step, res_scale, res_errs, done
  );
  modport slave (
    output start, sym_valid, sym_err, res_ready, abort,
    input  noise_scale, noise_en, busy, res_valid, res_step, res_scale, res_errs, done
  );
`else
  modport master (
    input  start, sym_valid, sym_err, res_ready,
    output noise_scale, noise_en, busy, res_valid, res_step, res_scale, res_errs, done
  );
  modport slave (
    output start, sym_valid, sym_err, res_ready,
    input  noise_scale, noise_en, busy, res_valid, res_step, res_scale, res_errs, done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/channel_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : channel_sweep_ctrl
// Brief    : Steps the AWGN channel through a noise-scale sweep and reports
//            per-step symbol error counts. Optional abort: CHAN_SWEEP_ABORT_EN.
// Revision : 1.0  initial release
// ============================================================================
module channel_sweep_ctrl #(
  parameter int NUM_STEPS     = 8,
  parameter int SCALE_START   = 0,
  parameter int SCALE_STEP    = 1150,
  parameter int SETTLE_CYC    = 64,
  parameter int SYMS_PER_STEP = 1024,
  parameter int CNT_W         = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  channel_sweep_if.master  bus
);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int SYM_W = $clog2(SYMS_PER_STEP + 1);
  localparam logic [17:0]      C_SCALE_START = 18'(SCALE_START);
  localparam logic [7:0]       C_LAST_STEP   = 8'(NUM_STEPS - 1);
  localparam logic [SET_W-1:0] C_SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [SYM_W-1:0] C_SYMS        = SYM_W'(SYMS_PER_STEP);
  localparam logic [CNT_W-1:0] C_ERR_MAX     = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2,
    S_REPORT  = 2'd3
  } state_t;

  state_t            r_state,     w_state_nxt;
  logic [7:0]        r_step,      w_step_nxt;
  logic [17:0]       r_scale,     w_scale_nxt;
  logic              r_noise_en,  w_noise_en_nxt;
  logic              r_busy,      w_busy_nxt;
  logic              r_res_valid, w_res_valid_nxt;
  logic              r_done,      w_done_nxt;
  logic [SET_W-1:0]  r_set_cnt,   w_set_cnt_nxt;
  logic [SYM_W-1:0]  r_sym_cnt,   w_sym_cnt_nxt;
  logic [CNT_W-1:0]  r_err_cnt,   w_err_cnt_nxt;
  logic [7:0]        r_res_step,  w_res_step_nxt;
  logic [17:0]       r_res_scale, w_res_scale_nxt;
  logic [CNT_W-1:0]  r_res_errs,  w_res_errs_nxt;

  logic signed [18:0] w_scale_sum;
  logic [17:0]        w_scale_sat;
  logic [SYM_W-1:0]   w_sym_inc;
  logic [CNT_W-1:0]   w_err_sat;
  logic               w_abort;

`ifdef CHAN_SWEEP_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  // 19-bit signed sum, clamped into the non-negative 18-bit signed range
  assign w_scale_sum = $signed({r_scale[17], r_scale}) + $signed(19'(SCALE_STEP));
  assign w_scale_sat = w_scale_sum[18] ? 18'd0 :
                       w_scale_sum[17] ? 18'h1FFFF : w_scale_sum[17:0];
  assign w_sym_inc   = r_sym_cnt + 1'b1;
  assign w_err_sat   = (r_err_cnt == C_ERR_MAX) ? r_err_cnt : r_err_cnt + 1'b1;

  always_comb begin
    w_state_nxt     = r_state;
    w_step_nxt      = r_step;
    w_scale_nxt     = r_scale;
    w_noise_en_nxt  = r_noise_en;
    w_busy_nxt      = r_busy;
    w_res_valid_nxt = r_res_valid;
    w_done_nxt      = 1'b0;
    w_set_cnt_nxt   = r_set_cnt;
    w_sym_cnt_nxt   = r_sym_cnt;
    w_err_cnt_nxt   = r_err_cnt;
    w_res_step_nxt  = r_res_step;
    w_res_scale_nxt = r_res_scale;
    w_res_errs_nxt  = r_res_errs;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !w_abort) begin
          w_state_nxt    = S_SETTLE;
          w_step_nxt     = 8'd0;
          w_scale_nxt    = C_SCALE_START;
          w_noise_en_nxt = 1'b1;
          w_busy_nxt     = 1'b1;
          w_set_cnt_nxt  = '0;
          w_sym_cnt_nxt  = '0;
          w_err_cnt_nxt  = '0;
        end
      end
      S_SETTLE: begin
        if (r_set_cnt == C_SETTLE_LAST) begin
          w_state_nxt   = S_MEASURE;
          w_set_cnt_nxt = '0;
        end else begin
          w_set_cnt_nxt = r_set_cnt + 1'b1;
        end
      end
      S_MEASURE: begin
        if (bus.sym_valid) begin
          w_sym_cnt_nxt = w_sym_inc;
          if (bus.sym_err) w_err_cnt_nxt = w_err_sat;
          // The symbol that completes the step is included in the result
          if (w_sym_inc == C_SYMS) begin
            w_state_nxt     = S_REPORT;
            w_res_valid_nxt = 1'b1;
            w_res_step_nxt  = r_step;
            w_res_scale_nxt = r_scale;
            w_res_errs_nxt  = bus.sym_err ? w_err_sat : r_err_cnt;
          end
        end
      end
      S_REPORT: begin
        if (bus.res_ready) begin
          w_res_valid_nxt = 1'b0;
          if (r_step == C_LAST_STEP) begin
            w_state_nxt    = S_IDLE;
            w_noise_en_nxt = 1'b0;
            w_busy_nxt     = 1'b0;
            w_done_nxt     = 1'b1;
          end else begin
            w_state_nxt   = S_SETTLE;
            w_step_nxt    = r_step + 8'd1;
            w_scale_nxt   = w_scale_sat;
            w_set_cnt_nxt = '0;
            w_sym_cnt_nxt = '0;
            w_err_cnt_nxt = '0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort && (r_state != S_IDLE)) begin
      w_state_nxt     = S_IDLE;
      w_noise_en_nxt  = 1'b0;
      w_busy_nxt      = 1'b0;
      w_res_valid_nxt = 1'b0;
      w_done_nxt      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_step      <= 8'd0;
      r_scale     <= C_SCALE_START;
      r_noise_en  <= 1'b0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
      r_set_cnt   <= '0;
      r_sym_cnt   <= '0;
      r_err_cnt   <= '0;
      r_res_step  <= 8'd0;
      r_res_scale <= 18'd0;
      r_res_errs  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_step      <= w_step_nxt;
      r_scale     <= w_scale_nxt;
      r_noise_en  <= w_noise_en_nxt;
      r_busy      <= w_busy_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_done      <= w_done_nxt;
      r_set_cnt   <= w_set_cnt_nxt;
      r_sym_cnt   <= w_sym_cnt_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_res_step  <= w_res_step_nxt;
      r_res_scale <= w_res_scale_nxt;
      r_res_errs  <= w_res_errs_nxt;
    end
  end

  assign bus.noise_scale = r_scale;
  assign bus.noise_en    = r_noise_en;
  assign bus.busy        = r_busy;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_step    = r_res_step;
  assign bus.res_scale   = r_res_scale;
  assign bus.res_errs    = r_res_errs;
  assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_channel_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_channel_sweep_ctrl
// Brief    : Randomized bench for channel_sweep_ctrl against a timeline model
//            of the sweep (scale clamping, error saturation, backpressure).
// Revision : 1.0  initial release
// ============================================================================
module tb_channel_sweep_ctrl;
  localparam int NUM_STEPS   = 6;
  localparam int SCALE_START = 127000;
  localparam int SCALE_STEP  = 1150;
  localparam int SETTLE_CYC  = 6;
  localparam int SYMS        = 24;
  localparam int CNT_W       = 4;
  localparam int ERR_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  channel_sweep_if #(.CNT_W(CNT_W)) bus ();

  channel_sweep_ctrl #(
    .NUM_STEPS    (NUM_STEPS),
    .SCALE_START  (SCALE_START),
    .SCALE_STEP   (SCALE_STEP),
    .SETTLE_CYC   (SETTLE_CYC),
    .SYMS_PER_STEP(SYMS),
    .CNT_W        (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Expected scale of step s, from the closed form clamped to the 18-bit signed range
  function automatic int exp_scale(input int s);
    longint v;
    v = longint'(SCALE_START) + longint'(s) * longint'(SCALE_STEP);
    if (v > 131071) v = 131071;
    if (v < 0) v = 0;
    return int'(v);
  endfunction

  task automatic drive_syms(input int pv, input int pe);
    bus.sym_valid = ($urandom_range(99) < pv);
    bus.sym_err   = ($urandom_range(99) < pe);
  endtask

  task automatic check_idle_after_kill();
    repeat (SETTLE_CYC + SYMS + 4) begin
      drive_syms(100, 50);
      bus.res_ready = 1'b1;
      @(negedge clk);
      check("kill_res_valid", bus.res_valid, 0);
      check("kill_done", bus.done, 0);
      check("kill_busy", bus.busy, 0);
    end
    bus.res_ready = 1'b0;
  endtask

  // kill_step: step whose MEASURE phase is cut short (-1 = none)
  task automatic run_sweep(input int kill_step, input bit kill_rst, input int long_hold_step);
    int syms, errs, pe, hold, exp_errs;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int s = 0; s < NUM_STEPS; s++) begin
      case ($urandom_range(3))
        0:       pe = 0;
        1:       pe = 25;
        2:       pe = 70;
        default: pe = 100;
      endcase
      if (s == 0) pe = 100;
      if (s == 1) pe = 0;
      for (int c = 0; c < SETTLE_CYC; c++) begin
        check("settle_busy", bus.busy, 1);
        check("settle_noise_en", bus.noise_en, 1);
        check("settle_scale", bus.noise_scale, exp_scale(s));
        check("settle_res_valid", bus.res_valid, 0);
        check("settle_done", bus.done, 0);
        drive_syms(70, pe);
        bus.start = ($urandom_range(3) == 0);
        @(negedge clk);
      end
      syms = 0;
      errs = 0;
      while (syms < SYMS) begin
        check("meas_res_valid", bus.res_valid, 0);
        check("meas_scale", bus.noise_scale, exp_scale(s));
        drive_syms(70, pe);
        bus.start = ($urandom_range(3) == 0);
        if (s == kill_step && syms == 3) begin
          bus.start = 1'b0;
          if (kill_rst) begin
            #2 rst = 1'b1;
            #1;
            check("rst_busy", bus.busy, 0);
            check("rst_noise_en", bus.noise_en, 0);
            check("rst_res_valid", bus.res_valid, 0);
            check("rst_scale", bus.noise_scale, SCALE_START);
            check("rst_done", bus.done, 0);
            @(negedge clk);
            rst = 1'b0;
          end else begin
`ifdef CHAN_SWEEP_ABORT_EN
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
            check("abort_busy", bus.busy, 0);
            check("abort_noise_en", bus.noise_en, 0);
            check("abort_res_valid", bus.res_valid, 0);
            check("abort_done", bus.done, 0);
`endif
          end
          check_idle_after_kill();
          return;
        end
        if (bus.sym_valid) begin
          syms++;
          if (bus.sym_err) errs++;
        end
        @(negedge clk);
      end
      bus.start = 1'b0;
      exp_errs = (errs > ERR_MAX) ? ERR_MAX : errs;
      check("res_valid", bus.res_valid, 1);
      check("res_step", bus.res_step, s);
      check("res_scale", bus.res_scale, exp_scale(s));
      check("res_errs", bus.res_errs, exp_errs);
      hold = (s == long_hold_step) ? 20 : $urandom_range(3);
      for (int h = 0; h < hold; h++) begin
        bus.res_ready = 1'b0;
        drive_syms(70, 50);
        @(negedge clk);
        check("hold_res_valid", bus.res_valid, 1);
        check("hold_res_step", bus.res_step, s);
        check("hold_res_scale", bus.res_scale, exp_scale(s));
        check("hold_res_errs", bus.res_errs, exp_errs);
        check("hold_scale", bus.noise_scale, exp_scale(s));
      end
      bus.res_ready = 1'b1;
      drive_syms(70, 50);
      @(negedge clk);
      bus.res_ready = 1'b0;
      check("xfer_res_valid", bus.res_valid, 0);
      if (s == NUM_STEPS - 1) begin
        check("done_pulse", bus.done, 1);
        check("done_busy", bus.busy, 0);
        check("done_noise_en", bus.noise_en, 0);
        @(negedge clk);
        check("done_cleared", bus.done, 0);
      end else begin
        check("step_done", bus.done, 0);
      end
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym_err   = 1'b0;
    bus.res_ready = 1'b0;
`ifdef CHAN_SWEEP_ABORT_EN
    bus.abort     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_noise_en", bus.noise_en, 0);
    check("reset_res_valid", bus.res_valid, 0);
    check("reset_done", bus.done, 0);
    check("reset_scale", bus.noise_scale, SCALE_START);
    check("reset_res_errs", bus.res_errs, 0);
    rst = 1'b0;

    run_sweep(-1, 1'b0, 2);
    run_sweep(-1, 1'b0, -1);
    run_sweep(2, 1'b1, -1);
    run_sweep(-1, 1'b0, 0);
`ifdef CHAN_SWEEP_ABORT_EN
    run_sweep(3, 1'b0, -1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (4) begin
      check("start_abort_busy", bus.busy, 0);
      check("start_abort_noise_en", bus.noise_en, 0);
      @(negedge clk);
    end
    run_sweep(-1, 1'b0, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
